// File: rtl/masked_counter_pkg.sv
// Shared types for the masked counter family: masking modes and the mode decode helper.
package masked_counter_pkg;

  typedef enum logic [1:0] {
    MODE_ZERO = 2'd0,
    MODE_HOLD = 2'd1,
    MODE_PASS = 2'd2
  } mode_t;

  // Encoding 3 is reserved and behaves exactly like MODE_PASS.
  localparam logic [1:0] MODE_RESERVED = 2'd3;

  function automatic logic mode_masks(input logic [1:0] mode);
    return (mode == MODE_ZERO) || (mode == MODE_HOLD);
  endfunction

endpackage

// File: rtl/mod_phase_tracker.sv
// Incremental modulo tracker: phase follows count mod div without a divider, clearing on
// the count wrap or when a new divisor is loaded.
module mod_phase_tracker #(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wrap,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic [DIV_W-1:0] phase
);

  localparam logic [DIV_W-1:0] ONE = 1;

  logic [DIV_W-1:0] phase_q, phase_d;

  // NOTE: combinational next-state uses blocking '=' and assigns a default first, so no latch is inferred.
  always_comb begin
    phase_d = phase_q;
    if (load) begin
      phase_d = '0;
    end else if (en) begin
      // With div==0 the compare target is all-ones; masking is off then, so the value is irrelevant.
      if (wrap || (phase_q == div - ONE)) phase_d = '0;
      else                                phase_d = phase_q + ONE;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) phase_q <= '0;
    else     phase_q <= phase_d;
  end

  assign phase = phase_q;

endmodule

// File: rtl/masked_counter.sv
// Free-running counter that masks multiples of a runtime divisor (zero, hold or pass), with a
// valid/ready divisor update that is applied only on the count wrap.
module masked_counter
  import masked_counter_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter int               DIV_W       = 4,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic [WIDTH-1:0] count_o,
  output logic             masked_o,
  output logic             wrap_o,
  output logic [DIV_W-1:0] active_div
);

  localparam logic [WIDTH-1:0] VAL_ONE = 1;

  logic [WIDTH-1:0] val_q, val_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             pend_valid_q, pend_valid_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             wrap_q, wrap_d;

  logic [DIV_W-1:0] phase;
  logic             wrap_edge;
  logic             xfer;
  logic             apply;
  logic             div_hit;

  assign wrap_edge = en && (val_q == '1);
  assign xfer      = cfg_valid && !pend_valid_q;
  assign apply     = wrap_edge && (xfer || pend_valid_q);
  // Mode-independent: the hold register tracks unmasked values even while in ZERO or PASS.
  assign div_hit   = (div_q != '0) && (phase == '0);

  mod_phase_tracker #(.DIV_W(DIV_W)) u_phase (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .wrap  (wrap_edge),
    .load  (apply),
    .div   (div_q),
    .phase (phase)
  );

  always_comb begin
    val_d        = val_q;
    hold_d       = hold_q;
    pend_valid_d = pend_valid_q;
    pend_div_d   = pend_div_q;
    div_d        = div_q;
    wrap_d       = wrap_edge;

    if (en) begin
      val_d = val_q + VAL_ONE;
      if (!div_hit) hold_d = val_q;
    end

    // A transfer landing on the wrap edge bypasses the pending slot entirely.
    if (wrap_edge) begin
      if (xfer)              div_d = cfg_div;
      else if (pend_valid_q) div_d = pend_div_q;
      pend_valid_d = 1'b0;
    end else if (xfer) begin
      pend_valid_d = 1'b1;
      pend_div_d   = cfg_div;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q        <= '0;
      hold_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_div_q   <= '0;
      div_q        <= DEFAULT_DIV;
      wrap_q       <= 1'b0;
    end else begin
      val_q        <= val_d;
      hold_q       <= hold_d;
      pend_valid_q <= pend_valid_d;
      pend_div_q   <= pend_div_d;
      div_q        <= div_d;
      wrap_q       <= wrap_d;
    end
  end

  assign masked_o   = div_hit && mode_masks(mode);
  assign cfg_ready  = !pend_valid_q;
  assign wrap_o     = wrap_q;
  assign active_div = div_q;

  always_comb begin
    count_o = val_q;
    case (mode)
      MODE_ZERO:                count_o = masked_o ? '0 : val_q;
      MODE_HOLD:                count_o = masked_o ? hold_q : val_q;
      MODE_PASS, MODE_RESERVED: count_o = val_q;
      default:                  count_o = val_q;
    endcase
  end

endmodule

// File: tb/tb_masked_counter.sv
// Self-checking bench for masked_counter: spec-derived vector tables, directed corner
// sequences and a randomized run against an arithmetic reference model.
module tb_masked_counter;

  localparam int WIDTH = 4;
  localparam int DIV_W = 4;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic             cfg_valid = 1'b0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic             cfg_ready;
  logic [WIDTH-1:0] count_o;
  logic             masked_o;
  logic             wrap_o;
  logic [DIV_W-1:0] active_div;

  int n_checks = 0;
  int n_err    = 0;

  masked_counter #(.WIDTH(WIDTH), .DIV_W(DIV_W), .DEFAULT_DIV(4'd3)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .cfg_valid  (cfg_valid),
    .cfg_div    (cfg_div),
    .cfg_ready  (cfg_ready),
    .count_o    (count_o),
    .masked_o   (masked_o),
    .wrap_o     (wrap_o),
    .active_div (active_div)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  // Reference model: val is the raw count, masking is val % div == 0, div changes only at val==0.
  int m_val, m_hold, m_div, m_pend, m_pend_div, m_wrap;

  function automatic int m_hit();
    if (m_div == 0) return 0;
    return (m_val % m_div) == 0 ? 1 : 0;
  endfunction

  function automatic int m_masked(input int md);
    return (m_hit() != 0 && md < 2) ? 1 : 0;
  endfunction

  function automatic int m_count(input int md);
    if (m_masked(md) != 0) return (md == 0) ? 0 : m_hold;
    return m_val;
  endfunction

  task automatic model_reset();
    m_val = 0; m_hold = 0; m_div = 3; m_pend = 0; m_pend_div = 0; m_wrap = 0;
  endtask

  task automatic model_edge(input int e, input int v, input int d);
    int wr, xf;
    wr = (e != 0 && m_val == MAXV) ? 1 : 0;
    xf = (v != 0 && m_pend == 0) ? 1 : 0;
    if (e != 0) begin
      if (m_hit() == 0) m_hold = m_val;
      m_val = (m_val + 1) % (MAXV + 1);
    end
    if (wr != 0) begin
      if (xf != 0)          m_div = d;
      else if (m_pend != 0) m_div = m_pend_div;
      m_pend = 0;
    end else if (xf != 0) begin
      m_pend = 1;
      m_pend_div = d;
    end
    m_wrap = wr;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int md);
    check({tag, ".count"},  32'(count_o),    32'(m_count(md)));
    check({tag, ".masked"}, 32'(masked_o),   32'(m_masked(md)));
    check({tag, ".wrap"},   32'(wrap_o),     32'(m_wrap));
    check({tag, ".ready"},  32'(cfg_ready),  32'(m_pend == 0));
    check({tag, ".div"},    32'(active_div), 32'(m_div));
  endtask

  task automatic step(input logic e, input logic [1:0] md, input logic v, input logic [3:0] d,
                      input string tag);
    en = e; mode = md; cfg_valid = v; cfg_div = d;
    @(posedge clk);
    model_edge(int'(e), int'(v), int'(d));
    @(negedge clk);
    check_all(tag, int'(md));
  endtask

  task automatic do_reset(input logic [1:0] md, input logic e);
    rst = 1'b1; mode = md; en = e; cfg_valid = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check_all("reset", int'(md));
  endtask

  typedef struct {
    logic       en;
    logic [1:0] mode;
    int         exp_count;
    int         exp_masked;
    int         exp_wrap;
  } vec_t;

  vec_t tbl[32];

  initial begin
    int zc[16] = '{1, 2, 0, 4, 5, 0, 7, 8, 0, 10, 11, 0, 13, 14, 0, 0};
    int hc[16] = '{1, 2, 2, 4, 5, 5, 7, 8, 8, 10, 11, 11, 13, 14, 14, 14};
    int ms[16] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 1};
    for (int i = 0; i < 16; i++) begin
      tbl[i]      = '{en: 1'b1, mode: 2'd0, exp_count: zc[i], exp_masked: ms[i], exp_wrap: (i == 15)};
      tbl[i + 16] = '{en: 1'b1, mode: 2'd1, exp_count: hc[i], exp_masked: ms[i], exp_wrap: (i == 15)};
    end

    model_reset();
    @(negedge clk);

    // Reset state and the spec sequences for ZERO then HOLD.
    do_reset(2'd0, 1'b1);
    check("reset.count0", 32'(count_o), 32'd0);
    check("reset.masked1", 32'(masked_o), 32'd1);
    for (int i = 0; i < 32; i++) begin
      if (i == 16) do_reset(2'd1, 1'b1);
      step(tbl[i].en, tbl[i].mode, 1'b0, 4'd0, "tbl");
      check("tbl.count",  32'(count_o),  32'(tbl[i].exp_count));
      check("tbl.masked", 32'(masked_o), 32'(tbl[i].exp_masked));
      check("tbl.wrap",   32'(wrap_o),   32'(tbl[i].exp_wrap));
    end

    // Divisor 5 requested at val=6: pending until the wrap.
    do_reset(2'd0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 2'd0, 1'b0, 4'd0, "pre5");
    step(1'b1, 2'd0, 1'b1, 4'd5, "req5");
    check("req5.ready_low", 32'(cfg_ready), 32'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 2'd0, 1'b0, 4'd0, "pend5");
    check("pend5.val15_div", 32'(active_div), 32'd3);
    check("pend5.val15_masked", 32'(masked_o), 32'd1);
    mode = 2'd1; #1;
    check("comb.hold_count", 32'(count_o), 32'd14);
    mode = 2'd2; #1;
    check("comb.pass_count", 32'(count_o), 32'd15);
    check("comb.pass_masked", 32'(masked_o), 32'd0);
    mode = 2'd0; #1;
    step(1'b1, 2'd0, 1'b0, 4'd0, "wrap5");
    check("wrap5.div", 32'(active_div), 32'd5);
    check("wrap5.ready", 32'(cfg_ready), 32'd1);
    check("wrap5.wrap", 32'(wrap_o), 32'd1);
    for (int i = 1; i <= 15; i++) begin
      step(1'b1, 2'd0, 1'b0, 4'd0, "div5");
      if (i == 5) check("div5.val5_masked", 32'(masked_o), 32'd1);
      if (i == 6) check("div5.val6_count", 32'(count_o), 32'd6);
    end

    // Transfer coincident with the wrap: applied immediately.
    step(1'b1, 2'd0, 1'b1, 4'd4, "coinc4");
    check("coinc4.div", 32'(active_div), 32'd4);
    check("coinc4.ready", 32'(cfg_ready), 32'd1);
    for (int i = 1; i <= 15; i++) begin
      step(1'b1, 2'd0, 1'b0, 4'd0, "div4");
      if (i == 8) check("div4.val8_masked", 32'(masked_o), 32'd1);
      if (i == 9) check("div4.val9_count", 32'(count_o), 32'd9);
    end

    // Divisor 0 disables masking; divisor 1 masks every value.
    step(1'b1, 2'd0, 1'b1, 4'd0, "set0");
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 2'd0, 1'b0, 4'd0, "div0");
      check("div0.masked", 32'(masked_o), 32'd0);
    end
    step(1'b1, 2'd0, 1'b1, 4'd1, "set1");
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 2'd0, 1'b0, 4'd0, "div1");
      check("div1.count", 32'(count_o), 32'd0);
    end

    // Freeze at val=7 with an update accepted while disabled, then reset discards it.
    do_reset(2'd0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 2'd0, 1'b0, 4'd0, "pre7");
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 2'd0, (i == 0), 4'd5, "frozen");
      check("frozen.count", 32'(count_o), 32'd7);
      check("frozen.ready", 32'(cfg_ready), 32'd0);
    end
    do_reset(2'd0, 1'b0);
    check("rst.count", 32'(count_o), 32'd0);
    check("rst.div", 32'(active_div), 32'd3);
    check("rst.ready", 32'(cfg_ready), 32'd1);
    check("rst.wrap", 32'(wrap_o), 32'd0);

    // Reset on what would have been the wrap edge must not produce a wrap pulse.
    for (int i = 0; i < 15; i++) step(1'b1, 2'd1, 1'b0, 4'd0, "pre15");
    do_reset(2'd1, 1'b1);
    check("rst_at_wrap.wrap", 32'(wrap_o), 32'd0);

    // Randomized run against the model.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end else begin
        step(($urandom_range(0, 9) < 8), 2'($urandom_range(0, 3)),
             ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), "rand");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
